bcd_calc_core: RTL and testbench

Parametrised BCD calculator datapath and control core. It replaces the fixed 4-digit save/ALU/FSM chain with one block that has `DIGITS` digits of entry, a signed accumulator, operator chaining and a digit-serial add/subtract engine. It sits between the keypad translation stage, which provides one-cycle key pulses with 4-bit codes, and the display driver, which takes BCD digits plus a sign flag.

---
 rtl/bcd_calc_core.sv | 237 +++++++++++++++++++++++
 tb/tb_bcd_calc_core.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calc_core.sv
// BCD calculator core: digit entry, signed accumulator with operator chaining,
// and a digit-serial add/subtract engine with a 10's-complement fix-up pass.
module bcd_calc_core #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic                disp_neg,
    output logic                busy,
    output logic                result_valid,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LAST_DIG = CW'(DIGITS - 1);

    localparam logic [2:0] ST_ENTRY_A = 3'd0;
    localparam logic [2:0] ST_OP_WAIT = 3'd1;
    localparam logic [2:0] ST_ENTRY_B = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_FIX     = 3'd4;
    localparam logic [2:0] ST_RESULT  = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    logic [2:0]    state;
    logic [W-1:0]  entry;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic          acc_neg;
    logic          op_sub;
    logic          to_result;

    // Engine: X and Y shift out LSD first, the result shifts in from the top.
    logic [W-1:0]  x_reg;
    logic [W-1:0]  y_reg;
    logic [W-1:0]  res_reg;
    logic [CW-1:0] dcnt;
    logic          cb;
    logic          eng_sub;
    logic          add_neg;

    logic          key_digit;
    logic          key_op;
    logic          key_clr;
    logic          key_eq;
    logic          zero_digit;
    logic [W-1:0]  entry_shift;

    always_comb begin
        key_digit   = key_valid && (key_code <= 4'd9);
        key_op      = key_valid && ((key_code == 4'hA) || (key_code == 4'hB));
        key_clr     = key_valid && (key_code == 4'hC);
        key_eq      = key_valid && (key_code == 4'hD);
        zero_digit  = (key_code == 4'd0);
        entry_shift = (entry << 4) | W'(key_code);
    end

    logic [3:0]   x_dig;
    logic [3:0]   y_dig;
    logic [3:0]   step_dig;
    logic [4:0]   sum;
    logic [4:0]   sum_adj;
    logic [4:0]   diff;
    logic [4:0]   diff_adj;
    logic         c_out;
    logic         last_dig;
    logic         eng_done;
    logic         done_neg;
    logic [W-1:0] res_next;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        step_dig = 4'd0;
        c_out    = 1'b0;
        x_dig    = x_reg[3:0];
        y_dig    = y_reg[3:0];
        sum      = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, cb};
        sum_adj  = sum - 5'd10;
        diff     = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, cb};
        diff_adj = diff + 5'd10;
        if (eng_sub) begin
            c_out    = diff[4];
            step_dig = diff[4] ? diff_adj[3:0] : diff[3:0];
        end else begin
            c_out    = (sum > 5'd9);
            step_dig = c_out ? sum_adj[3:0] : sum[3:0];
        end
        res_next = (res_reg >> 4) | (W'(step_dig) << (W - 4));
        last_dig = (dcnt == LAST_DIG);
        // A borrow out of the FIX pass is expected and ignored.
        eng_done = last_dig && ((state == ST_FIX) || ((state == ST_EXEC) && !c_out));
        done_neg = (state == ST_FIX) || (!eng_sub && add_neg);
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state        <= ST_ENTRY_A;
            entry        <= '0;
            cnt          <= '0;
            acc          <= '0;
            acc_neg      <= 1'b0;
            op_sub       <= 1'b0;
            to_result    <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            res_reg      <= '0;
            dcnt         <= '0;
            cb           <= 1'b0;
            eng_sub      <= 1'b0;
            add_neg      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (key_clr) begin
                state   <= ST_ENTRY_A;
                entry   <= '0;
                cnt     <= '0;
                acc     <= '0;
                acc_neg <= 1'b0;
                op_sub  <= 1'b0;
            end else begin
                case (state)
                    ST_ENTRY_A, ST_ENTRY_B: begin
                        if (key_digit) begin
                            if (cnt != CNT_FULL) begin
                                entry <= entry_shift;
                                if (!(zero_digit && (entry == '0)))
                                    cnt <= cnt + CNT_ONE;
                            end
                        end else if (key_op && (state == ST_ENTRY_A)) begin
                            acc     <= entry;
                            acc_neg <= 1'b0;
                            op_sub  <= key_code[0];
                            state   <= ST_OP_WAIT;
                        end else if ((key_op || key_eq) && (state == ST_ENTRY_B)) begin
                            // Same effective sign: magnitude add; otherwise subtract
                            // the smaller-signed side from the other.
                            if (op_sub == acc_neg) begin
                                eng_sub <= 1'b0;
                                x_reg   <= acc;
                                y_reg   <= entry;
                                add_neg <= acc_neg;
                            end else begin
                                eng_sub <= 1'b1;
                                x_reg   <= acc_neg ? entry : acc;
                                y_reg   <= acc_neg ? acc : entry;
                                add_neg <= 1'b0;
                            end
                            res_reg   <= '0;
                            cb        <= 1'b0;
                            dcnt      <= '0;
                            to_result <= key_eq;
                            if (key_op)
                                op_sub <= key_code[0];
                            state <= ST_EXEC;
                        end
                    end
                    ST_OP_WAIT: begin
                        if (key_op) begin
                            op_sub <= key_code[0];
                        end else if (key_digit) begin
                            entry <= W'(key_code);
                            cnt   <= zero_digit ? '0 : CNT_ONE;
                            state <= ST_ENTRY_B;
                        end
                    end
                    ST_RESULT: begin
                        if (key_digit) begin
                            entry   <= W'(key_code);
                            cnt     <= zero_digit ? '0 : CNT_ONE;
                            acc     <= '0;
                            acc_neg <= 1'b0;
                            state   <= ST_ENTRY_A;
                        end else if (key_op) begin
                            op_sub <= key_code[0];
                            state  <= ST_OP_WAIT;
                        end
                    end
                    ST_EXEC, ST_FIX: begin
                        x_reg   <= x_reg >> 4;
                        y_reg   <= y_reg >> 4;
                        res_reg <= res_next;
                        cb      <= c_out;
                        dcnt    <= dcnt + CNT_ONE;
                        if (eng_done) begin
                            acc          <= res_next;
                            acc_neg      <= done_neg && (res_next != '0);
                            result_valid <= 1'b1;
                            state        <= to_result ? ST_RESULT : ST_OP_WAIT;
                        end else if (last_dig && c_out) begin
                            if (eng_sub) begin
                                // Negative difference: recompute as 0 - result.
                                x_reg   <= '0;
                                y_reg   <= res_next;
                                res_reg <= '0;
                                cb      <= 1'b0;
                                dcnt    <= '0;
                                state   <= ST_FIX;
                            end else begin
                                state <= ST_ERR;
                            end
                        end
                    end
                    ST_ERR: begin
                    end
                    default: state <= ST_ENTRY_A;
                endcase
            end
        end
    end

    always_comb begin
        disp_bcd = entry;
        disp_neg = 1'b0;
        case (state)
            ST_OP_WAIT, ST_RESULT: begin
                disp_bcd = acc;
                disp_neg = acc_neg;
            end
            ST_ERR:  disp_bcd = '0;
            default: ;
        endcase
        busy = (state == ST_EXEC) || (state == ST_FIX);
        err  = (state == ST_ERR);
    end

endmodule

// File: tb/tb_bcd_calc_core.sv
// Self-checking bench for bcd_calc_core: directed vector table, hand-timed
// busy-window sequences, and random keys against a decimal reference model.
module tb_bcd_calc_core;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] disp_bcd;
    logic         disp_neg;
    logic         busy;
    logic         result_valid;
    logic         err;

    bcd_calc_core #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .disp_bcd     (disp_bcd),
        .disp_neg     (disp_neg),
        .busy         (busy),
        .result_valid (result_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r;
        int t;
        r = 0;
        t = (v < 0) ? -v : v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | ((t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    // Press one key, then follow any busy window to its end. Outputs are
    // sampled on falling edges, in the first cycle after busy drops.
    task automatic apply(input logic [3:0] code, output int nbusy, output int rv,
                         output int disp, output int neg, output int e);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 3 * DIGITS) begin
            nbusy++;
            @(negedge clk);
        end
        rv   = int'(result_valid);
        disp = int'(disp_bcd);
        neg  = int'(disp_neg);
        e    = int'(err);
    endtask

    // Directed vectors: key, expected display (BCD), sign, busy length, pulse, err.
    typedef struct {
        logic [3:0] code;
        int         disp;
        bit         neg;
        int         nbusy;
        bit         rv;
        bit         err;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [3:0] c, input int d, input bit n, input int b,
                           input bit r, input bit e);
        vec_t t;
        t.code  = c;
        t.disp  = d;
        t.neg   = n;
        t.nbusy = b;
        t.rv    = r;
        t.err   = e;
        tbl.push_back(t);
    endtask

    // Reference model: plain decimal integers and a signed accumulator.
    typedef enum int {M_A, M_OPW, M_B, M_RES, M_ERR} mmode_t;
    mmode_t m_mode;
    int     m_entry;
    int     m_cnt;
    int     m_acc;
    bit     m_sub;
    int     p10;

    task automatic model_key(input int code, output int e_busy, output int e_rv);
        int r;
        bit subpath;
        e_busy = 0;
        e_rv   = 0;
        if (code == 12) begin
            m_mode  = M_A;
            m_entry = 0;
            m_cnt   = 0;
            m_acc   = 0;
            m_sub   = 0;
        end else if (m_mode != M_ERR) begin
            if (code <= 9) begin
                if (m_mode == M_A || m_mode == M_B) begin
                    if (m_cnt < DIGITS) begin
                        if (!(code == 0 && m_entry == 0)) m_cnt++;
                        m_entry = m_entry * 10 + code;
                    end
                end else begin
                    m_entry = code;
                    m_cnt   = (code != 0) ? 1 : 0;
                    if (m_mode == M_RES) begin
                        m_acc  = 0;
                        m_mode = M_A;
                    end else begin
                        m_mode = M_B;
                    end
                end
            end else if ((code == 10 || code == 11) && m_mode != M_B) begin
                if (m_mode == M_A) m_acc = m_entry;
                m_sub  = (code == 11);
                m_mode = M_OPW;
            end else if ((code == 10 || code == 11 || code == 13) && m_mode == M_B) begin
                r       = m_sub ? m_acc - m_entry : m_acc + m_entry;
                subpath = (m_sub != (m_acc < 0));
                e_busy  = DIGITS;
                if (r >= p10 || r <= -p10) begin
                    m_mode = M_ERR;
                end else begin
                    if (subpath && r < 0) e_busy = 2 * DIGITS;
                    e_rv   = 1;
                    m_acc  = r;
                    m_mode = (code == 13) ? M_RES : M_OPW;
                    if (code != 13) m_sub = (code == 11);
                end
            end
        end
    endtask

    function automatic int model_disp();
        if (m_mode == M_OPW || m_mode == M_RES) return to_bcd(m_acc);
        if (m_mode == M_ERR) return 0;
        return to_bcd(m_entry);
    endfunction

    initial begin
        int nb, rv, dd, ng, ee;
        int e_busy, e_rv;
        int seen, n, code, sel;

        p10 = 1;
        for (int i = 0; i < DIGITS; i++) p10 = p10 * 10;

        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_disp", disp_bcd, 0);
        check("reset_neg", disp_neg, 0);
        check("reset_busy", busy, 0);
        check("reset_rv", result_valid, 0);
        check("reset_err", err, 0);

        add_vec(4'hE, 'h0000, 0, 0, 0, 0);
        add_vec(4'hF, 'h0000, 0, 0, 0, 0);
        add_vec(4'h1, 'h0001, 0, 0, 0, 0);
        add_vec(4'h2, 'h0012, 0, 0, 0, 0);
        add_vec(4'h3, 'h0123, 0, 0, 0, 0);
        add_vec(4'hA, 'h0123, 0, 0, 0, 0);
        add_vec(4'h4, 'h0004, 0, 0, 0, 0);
        add_vec(4'h5, 'h0045, 0, 0, 0, 0);
        add_vec(4'hD, 'h0168, 0, 4, 1, 0);
        add_vec(4'h5, 'h0005, 0, 0, 0, 0);
        add_vec(4'hB, 'h0005, 0, 0, 0, 0);
        add_vec(4'h1, 'h0001, 0, 0, 0, 0);
        add_vec(4'h2, 'h0012, 0, 0, 0, 0);
        add_vec(4'hD, 'h0007, 1, 8, 1, 0);
        add_vec(4'hA, 'h0007, 1, 0, 0, 0);
        add_vec(4'h2, 'h0002, 0, 0, 0, 0);
        add_vec(4'h0, 'h0020, 0, 0, 0, 0);
        add_vec(4'hD, 'h0013, 0, 4, 1, 0);
        add_vec(4'h9, 'h0009, 0, 0, 0, 0);
        add_vec(4'h9, 'h0099, 0, 0, 0, 0);
        add_vec(4'h9, 'h0999, 0, 0, 0, 0);
        add_vec(4'h9, 'h9999, 0, 0, 0, 0);
        add_vec(4'hA, 'h9999, 0, 0, 0, 0);
        add_vec(4'h1, 'h0001, 0, 0, 0, 0);
        add_vec(4'hD, 'h0000, 0, 4, 0, 1);
        add_vec(4'h3, 'h0000, 0, 0, 0, 1);
        add_vec(4'hD, 'h0000, 0, 0, 0, 1);
        add_vec(4'hC, 'h0000, 0, 0, 0, 0);
        add_vec(4'h0, 'h0000, 0, 0, 0, 0);
        add_vec(4'h0, 'h0000, 0, 0, 0, 0);
        add_vec(4'h7, 'h0007, 0, 0, 0, 0);
        add_vec(4'h1, 'h0071, 0, 0, 0, 0);
        add_vec(4'h2, 'h0712, 0, 0, 0, 0);
        add_vec(4'h3, 'h7123, 0, 0, 0, 0);
        add_vec(4'h4, 'h7123, 0, 0, 0, 0);
        add_vec(4'hC, 'h0000, 0, 0, 0, 0);
        add_vec(4'h1, 'h0001, 0, 0, 0, 0);
        add_vec(4'hA, 'h0001, 0, 0, 0, 0);
        add_vec(4'h2, 'h0002, 0, 0, 0, 0);
        add_vec(4'hB, 'h0003, 0, 4, 1, 0);
        add_vec(4'h3, 'h0003, 0, 0, 0, 0);
        add_vec(4'hD, 'h0000, 0, 4, 1, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].code, nb, rv, dd, ng, ee);
            check($sformatf("vec%0d_disp", i), dd, tbl[i].disp);
            check($sformatf("vec%0d_neg", i), ng, tbl[i].neg);
            check($sformatf("vec%0d_busy", i), nb, tbl[i].nbusy);
            check($sformatf("vec%0d_rv", i), rv, tbl[i].rv);
            check($sformatf("vec%0d_err", i), ee, tbl[i].err);
        end

        // C during the third busy cycle of 9-12 aborts with no result pulse.
        apply(4'hC, nb, rv, dd, ng, ee);
        apply(4'h9, nb, rv, dd, ng, ee);
        apply(4'hB, nb, rv, dd, ng, ee);
        apply(4'h1, nb, rv, dd, ng, ee);
        apply(4'h2, nb, rv, dd, ng, ee);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hD;
        @(negedge clk);
        key_valid = 1'b0;
        check("abort_busy1", busy, 1);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy3", busy, 1);
        key_valid = 1'b1;
        key_code  = 4'hC;
        @(negedge clk);
        key_valid = 1'b0;
        check("abort_busy_low", busy, 0);
        check("abort_disp", disp_bcd, 0);
        check("abort_neg", disp_neg, 0);
        check("abort_rv", result_valid, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(result_valid);
        end
        check("abort_no_rv_later", seen, 0);
        apply(4'h3, nb, rv, dd, ng, ee);
        check("abort_then_entry", dd, 'h0003);

        // A digit sent in the first busy cycle is dropped.
        apply(4'hC, nb, rv, dd, ng, ee);
        apply(4'h2, nb, rv, dd, ng, ee);
        apply(4'hA, nb, rv, dd, ng, ee);
        apply(4'h3, nb, rv, dd, ng, ee);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hD;
        @(negedge clk);
        key_code  = 4'h7;
        @(negedge clk);
        key_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("drop_busy_rest", n, DIGITS - 1);
        check("drop_rv", result_valid, 1);
        check("drop_disp", disp_bcd, 'h0005);
        @(negedge clk);
        check("drop_rv_single", result_valid, 0);
        apply(4'h1, nb, rv, dd, ng, ee);
        check("drop_new_entry", dd, 'h0001);

        // A key coincident with the last busy cycle is dropped.
        apply(4'hC, nb, rv, dd, ng, ee);
        apply(4'h4, nb, rv, dd, ng, ee);
        apply(4'hA, nb, rv, dd, ng, ee);
        apply(4'h5, nb, rv, dd, ng, ee);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hD;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (DIGITS - 1) @(negedge clk);
        check("last_busy_high", busy, 1);
        key_valid = 1'b1;
        key_code  = 4'h8;
        @(negedge clk);
        key_valid = 1'b0;
        check("last_busy_low", busy, 0);
        check("last_rv", result_valid, 1);
        check("last_disp", disp_bcd, 'h0009);
        @(negedge clk);
        check("last_disp_hold", disp_bcd, 'h0009);

        // Random keys against the reference model.
        apply(4'hC, nb, rv, dd, ng, ee);
        model_key(12, e_busy, e_rv);
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 55)      code = int'($urandom_range(0, 9));
            else if (sel < 72) code = 10 + int'($urandom_range(0, 1));
            else if (sel < 84) code = 13;
            else if (sel < 88) code = 12;
            else if (sel < 92) code = 14 + int'($urandom_range(0, 1));
            else               code = 9;
            model_key(code, e_busy, e_rv);
            apply(4'(code), nb, rv, dd, ng, ee);
            check($sformatf("rnd%0d_k%0d_disp", k, code), dd, model_disp());
            check($sformatf("rnd%0d_k%0d_neg", k, code), ng,
                  ((m_mode == M_OPW || m_mode == M_RES) && m_acc < 0) ? 1 : 0);
            check($sformatf("rnd%0d_k%0d_busy", k, code), nb, e_busy);
            check($sformatf("rnd%0d_k%0d_rv", k, code), rv, e_rv);
            check($sformatf("rnd%0d_k%0d_err", k, code), ee, (m_mode == M_ERR) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
